// File: rtl/alm_pkg.sv
// Shared types and defaults for the approximate-log-multiplier dot-product accumulator.
package alm_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam int ALM_PROD_W = 32;
   localparam int ALM_ACC_W  = 40;
   localparam int ALM_LEN_W  = 8;

   // Two's-complement add overflow: operands agree in sign, result does not.
   function automatic logic add_ovf(input logic a_sign, input logic b_sign, input logic s_sign);
      return (a_sign == b_sign) && (s_sign != a_sign);
   endfunction

endpackage

// File: rtl/alm_sat_add.sv
// Combinational signed adder with overflow flag; clamps on overflow when ALM_DOT_ACC_SAT_EN is defined.
module alm_sat_add
   import alm_pkg::*;
#(
   parameter int W = ALM_ACC_W
) (
   input  logic signed [W-1:0] a_i,
   input  logic signed [W-1:0] b_i,
   output logic signed [W-1:0] sum_o,
   output logic                ovf_o
);

   logic signed [W-1:0] raw;

   assign raw   = a_i + b_i;
   assign ovf_o = add_ovf(a_i[W-1], b_i[W-1], raw[W-1]);

`ifdef ALM_DOT_ACC_SAT_EN
   localparam logic signed [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

   // Overflow direction follows the shared operand sign.
   assign sum_o = ovf_o ? (a_i[W-1] ? MIN_V : MAX_V) : raw;
`else
   assign sum_o = raw;
`endif

endmodule

// File: rtl/alm_dot_accumulator.sv
// Streams signed products into a wide accumulator and presents the held vector sum.
// Build option: ALM_DOT_ACC_SAT_EN selects saturating instead of wrapping accumulation.
module alm_dot_accumulator
   import alm_pkg::*;
#(
   parameter int PROD_W = ALM_PROD_W,
   parameter int ACC_W  = ALM_ACC_W,
   parameter int LEN_W  = ALM_LEN_W
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic [LEN_W-1:0]  i_len,
   output logic              o_busy,
   input  logic              i_prod_valid,
   input  logic [PROD_W-1:0] i_prod,
   output logic              o_prod_ready,
   output logic              o_acc_valid,
   output logic [ACC_W-1:0]  o_acc,
   input  logic              i_acc_ready,
   output logic              o_ovf
);

   state_e               state_q;
   logic signed [ACC_W-1:0] acc_q;
   logic signed [ACC_W-1:0] acc_d;
   logic signed [ACC_W-1:0] prod_ext;
   logic [LEN_W-1:0]     cnt_q;
   logic                 ovf_q;
   logic                 add_ovf_d;
   logic                 busy_q;
   logic                 prod_rdy_q;
   logic                 acc_vld_q;

   assign prod_ext = {{(ACC_W-PROD_W){i_prod[PROD_W-1]}}, i_prod};

   alm_sat_add #(.W(ACC_W)) u_add (
      .a_i   (acc_q),
      .b_i   (prod_ext),
      .sum_o (acc_d),
      .ovf_o (add_ovf_d)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         busy_q     <= 1'b0;
         prod_rdy_q <= 1'b0;
         acc_vld_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (i_start) begin
                  acc_q  <= '0;
                  ovf_q  <= 1'b0;
                  busy_q <= 1'b1;
                  if (i_len != '0) begin
                     cnt_q      <= i_len;
                     state_q    <= ACCUM;
                     prod_rdy_q <= 1'b1;
                  end else begin
                     state_q   <= DONE;
                     acc_vld_q <= 1'b1;
                  end
               end
            end
            ACCUM: begin
               if (i_prod_valid) begin
                  acc_q <= acc_d;
                  cnt_q <= cnt_q - LEN_W'(1);
                  if (add_ovf_d) ovf_q <= 1'b1;
                  if (cnt_q == LEN_W'(1)) begin
                     state_q    <= DONE;
                     prod_rdy_q <= 1'b0;
                     acc_vld_q  <= 1'b1;
                  end
               end
            end
            DONE: begin
               // A start seen on the release edge is dropped, not queued.
               if (i_acc_ready) begin
                  state_q   <= IDLE;
                  acc_vld_q <= 1'b0;
                  busy_q    <= 1'b0;
               end
            end
            default: begin
               state_q    <= IDLE;
               busy_q     <= 1'b0;
               prod_rdy_q <= 1'b0;
               acc_vld_q  <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy       = busy_q;
   assign o_prod_ready = prod_rdy_q;
   assign o_acc_valid  = acc_vld_q;
   assign o_acc        = acc_q;
   assign o_ovf        = ovf_q;

endmodule

// File: tb/tb_alm_dot_accumulator.sv
// Randomized scoreboard bench for alm_dot_accumulator (40-bit main instance, 33-bit overflow instance).
module tb_alm_dot_accumulator;

   typedef struct {
      longint acc;
      bit     ovf;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst_n;
   logic               i_start;
   logic [7:0]         i_len;
   logic               o_busy;
   logic               i_prod_valid;
   logic [31:0]        i_prod;
   logic               o_prod_ready;
   logic               o_acc_valid;
   logic signed [39:0] o_acc;
   logic               i_acc_ready;
   logic               o_ovf;

   logic               s_start;
   logic [7:0]         s_len;
   logic               s_busy;
   logic               s_pv;
   logic [31:0]        s_prod;
   logic               s_pr;
   logic               s_av;
   logic signed [32:0] s_acc;
   logic               s_ovf;

   int   checks   = 0;
   int   failures = 0;
   exp_t sb_q[$];

   alm_dot_accumulator #(.PROD_W(32), .ACC_W(40), .LEN_W(8)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_len(i_len), .o_busy(o_busy),
      .i_prod_valid(i_prod_valid), .i_prod(i_prod), .o_prod_ready(o_prod_ready),
      .o_acc_valid(o_acc_valid), .o_acc(o_acc), .i_acc_ready(i_acc_ready), .o_ovf(o_ovf)
   );

   alm_dot_accumulator #(.PROD_W(32), .ACC_W(33), .LEN_W(8)) dut33 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(s_start), .i_len(s_len), .o_busy(s_busy),
      .i_prod_valid(s_pv), .i_prod(s_prod), .o_prod_ready(s_pr),
      .o_acc_valid(s_av), .o_acc(s_acc), .i_acc_ready(1'b1), .o_ovf(s_ovf)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Exact running sum; leaving the ACC_W range flags overflow, then wraps or clamps.
   function automatic exp_t model(input longint p[$], input int accw);
      longint mx = (longint'(1) <<< (accw - 1)) - 1;
      longint mn = -mx - 1;
      exp_t   e;
      e.acc = 0;
      e.ovf = 1'b0;
      foreach (p[i]) begin
         e.acc += p[i];
         if (e.acc > mx || e.acc < mn) begin
            e.ovf = 1'b1;
`ifdef ALM_DOT_ACC_SAT_EN
            e.acc = (e.acc > mx) ? mx : mn;
`else
            e.acc = (e.acc > mx) ? e.acc - (mx - mn + 1) : e.acc + (mx - mn + 1);
`endif
         end
      end
      return e;
   endfunction

   always @(negedge clk) begin
      if (rst_n === 1'b1 && o_acc_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result actual=%0d required=no_result", longint'(o_acc));
         end else begin
            chk("result_acc", longint'(o_acc), sb_q[0].acc);
            chk("result_ovf", longint'(o_ovf), longint'(sb_q[0].ovf));
            if (i_acc_ready) void'(sb_q.pop_front());
         end
      end
   end

   task automatic run_vec(input longint p[$], input bit gaps, input int hold, input bit pokes);
      int   n = p.size();
      int   guard;
      exp_t e = model(p, 40);
      @(posedge clk); #1;
      i_start     = 1'b1;
      i_len       = 8'(n);
      i_acc_ready = (hold == 0);
      sb_q.push_back(e);
      @(posedge clk); #1;
      i_start = 1'b0;
      i_len   = 8'($urandom);
      if (n == 0) begin
         chk("zero_len_prod_ready", longint'(o_prod_ready), 0);
         chk("zero_len_acc_valid", longint'(o_acc_valid), 1);
      end
      foreach (p[k]) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               i_prod_valid = 1'b0;
               i_prod       = $urandom;
               @(posedge clk); #1;
            end
         end
         i_prod_valid = 1'b1;
         i_prod       = 32'(p[k]);
         guard = 0;
         while (o_prod_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
         end
         if (guard >= 50) begin
            checks++;
            failures++;
            $display("FAIL prod_ready_timeout actual=0 required=1");
         end
         @(posedge clk); #1;
      end
      i_prod_valid = 1'b0;
      if (n != 0) chk("latency_acc_valid", longint'(o_acc_valid), 1);
      repeat (hold) begin
         i_start = pokes;
         i_len   = 8'd5;
         @(posedge clk); #1;
      end
      if (hold > 0) chk("held_busy", longint'(o_busy), 1);
      i_acc_ready = 1'b1;
      i_start     = pokes;
      guard = 0;
      while (o_acc_valid === 1'b1 && guard < 50) begin
         @(posedge clk); #1;
         i_start = 1'b0;
         guard++;
      end
      i_start = 1'b0;
      if (guard >= 50) begin
         checks++;
         failures++;
         $display("FAIL acc_handshake_timeout actual=1 required=0");
      end
      chk("idle_busy", longint'(o_busy), 0);
      chk("idle_prod_ready", longint'(o_prod_ready), 0);
      chk("idle_acc_retained", longint'(o_acc), e.acc);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      longint v[$];
      exp_t   e33;
      rst_n = 1'b0; i_start = 1'b0; i_len = '0; i_prod_valid = 1'b0; i_prod = '0; i_acc_ready = 1'b1;
      s_start = 1'b0; s_len = '0; s_pv = 1'b0; s_prod = '0;
      #12;
      chk("rst_busy", longint'(o_busy), 0);
      chk("rst_prod_ready", longint'(o_prod_ready), 0);
      chk("rst_acc_valid", longint'(o_acc_valid), 0);
      chk("rst_acc", longint'(o_acc), 0);
      chk("rst_ovf", longint'(o_ovf), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      v = {100, -50, 7};
      run_vec(v, 1'b0, 0, 1'b0);
      run_vec(v, 1'b1, 5, 1'b1);
      v = {};
      run_vec(v, 1'b0, 0, 1'b0);

      // Abort a 4-long vector after two products.
      @(posedge clk); #1;
      i_start = 1'b1; i_len = 8'd4;
      @(posedge clk); #1;
      i_start = 1'b0; i_prod_valid = 1'b1; i_prod = 32'd1000;
      @(posedge clk); #1;
      i_prod = 32'd2000;
      @(posedge clk); #1;
      i_prod_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_busy", longint'(o_busy), 0);
      chk("midrst_prod_ready", longint'(o_prod_ready), 0);
      chk("midrst_acc_valid", longint'(o_acc_valid), 0);
      chk("midrst_acc", longint'(o_acc), 0);
      chk("midrst_ovf", longint'(o_ovf), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      v = {5, -9};
      run_vec(v, 1'b0, 0, 1'b0);

      v = {};
      repeat (255) v.push_back(-64'sd2147483648);
      run_vec(v, 1'b0, 0, 1'b0);
      chk("maxlen_const", longint'(o_acc), -64'sd547608330240);

      repeat (20) begin
         v = {};
         repeat ($urandom_range(1, 12)) v.push_back(longint'($signed(32'($urandom))));
         run_vec(v, 1'b1, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      // Narrow accumulator overflow on three maximum positive products.
      v = {64'sh7FFFFFFF, 64'sh7FFFFFFF, 64'sh7FFFFFFF};
      e33 = model(v, 33);
      @(posedge clk); #1;
      s_start = 1'b1; s_len = 8'd3;
      @(posedge clk); #1;
      s_start = 1'b0; s_pv = 1'b1; s_prod = 32'h7FFFFFFF;
      repeat (3) begin
         @(posedge clk); #1;
      end
      s_pv = 1'b0;
      chk("ovf33_valid", longint'(s_av), 1);
      chk("ovf33_acc", longint'(s_acc), e33.acc);
      chk("ovf33_flag", longint'(s_ovf), 1);
`ifdef ALM_DOT_ACC_SAT_EN
      chk("ovf33_const", longint'(s_acc), 64'sd4294967295);
`else
      chk("ovf33_const", longint'(s_acc), -64'sd2147483651);
`endif
      @(posedge clk); #1;
      chk("ovf33_idle", longint'(s_busy), 0);

      repeat (3) @(posedge clk);
      chk("scoreboard_drained", longint'(sb_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alm_dot_accumulator.md
Name: alm_dot_accumulator

Overview:
- Sequential stage directly downstream of the 16x16 approximate log multiplier.
- Consumes a stream of 32-bit signed products over a valid/ready handshake and accumulates a vector of programmable length into a wide signed sum.
- Presents the sum as a held result with its own valid/ready handshake.
- Used to build dot-product / FIR datapaths from the approximate multiplier.

Parameters:
- PROD_W, 32, width of incoming signed product; matches multiplier output.
- ACC_W, 40, accumulator/result width; legal range PROD_W+1 .. 64.
- LEN_W, 8, width of vector-length field; max vector length 2^LEN_W-1.

Ports:
- i_clk  input  1  clock, all state updates on rising edge.
- i_rst_n  input  1  reset, asynchronous assert, active-low.
- i_start  input  1  start pulse; sampled only in IDLE.
- i_len  input  LEN_W  number of products in vector, captured with i_start.
- o_busy  output  1  high in ACCUM and DONE.
- i_prod_valid  input  1  product valid.
- i_prod  input  PROD_W  signed product.
- o_prod_ready  output  1  accepting products; high only in ACCUM.
- o_acc_valid  output  1  result valid; high only in DONE.
- o_acc  output  ACC_W  signed accumulated result.
- i_acc_ready  input  1  consumer accepts result.
- o_ovf  output  1  sticky per-vector overflow flag, valid with o_acc_valid.

Behaviour:
- Reset: i_rst_n low forces the following immediately, independent of clock:
  - state=IDLE; accumulator, count, o_acc, o_ovf = 0; o_busy, o_prod_ready, o_acc_valid = 0.
  - Reset mid-vector discards the partial sum; no result is emitted.
- Clock and reset use the decided scheme: one clock, reset asynchronous and active-low.
- FSM states: IDLE, ACCUM, DONE (enum in package).
- IDLE:
  - i_start=1 and i_len!=0: clear accumulator and o_ovf, load count=i_len, go to ACCUM.
  - i_start=1 and i_len==0: clear accumulator and o_ovf, go to DONE; o_acc=0 is valid next cycle.
- ACCUM:
  - o_prod_ready=1.
  - Each cycle with i_prod_valid&&o_prod_ready: acc <= acc + sign_extend(i_prod), count <= count-1.
  - Handshake while count==1: go to DONE.
  - Throughput 1 product/cycle; no bubbles required.
- DONE:
  - o_acc_valid=1; o_acc and o_ovf held stable until handshake.
  - i_acc_valid&&i_acc_ready (o_acc_valid&&i_acc_ready): go to IDLE. o_acc retains its last value in IDLE.
- Latency: o_acc_valid asserts the cycle after the final product handshake.
- i_start outside IDLE is ignored. i_start in the same cycle as the DONE->IDLE handshake is also ignored; it must be re-asserted.
- Arithmetic:
  - Signed two's complement; overflow is detected when the operands have the same sign and the result sign differs.
  - Overflow sets o_ovf, which is sticky until the next start.
- i_len is captured at start; later changes have no effect.

Optional Feature:
- Macro: ALM_DOT_ACC_SAT_EN.
- Defined: on overflow, the accumulator clamps to +(2^(ACC_W-1)-1) or -2^(ACC_W-1) and remains saturated until the next start.
  - Further products are still consumed; their effect is computed from the clamped value.
- Undefined: modular wrap at ACC_W bits.
- o_ovf behaves identically in both builds.

Decomposition:
- Shared package alm_pkg:
  - state enum typedef (IDLE/ACCUM/DONE);
  - default width constants PROD_W/ACC_W/LEN_W;
  - helper function for signed-overflow detect.
- One natural sub-module: alm_sat_add, a combinational ACC_W-bit signed adder.
  - Outputs sum and overflow.
  - Saturation logic is compiled under ALM_DOT_ACC_SAT_EN.

Test Plan:
- Basic vector: i_len=3, products 100, -50, 7 streamed on back-to-back cycles.
  - o_acc_valid rises 1 cycle after third handshake; o_acc=57; o_ovf=0.
- Backpressure both sides:
  - i_prod_valid gapped randomly; i_acc_ready held low 5 cycles.
  - o_acc stays 57 and stable; i_start pulses during DONE are ignored.
  - Result completes after i_acc_ready goes high.
- Zero length: i_start with i_len=0.
  - o_prod_ready never rises; o_acc_valid next cycle with o_acc=0.
- Overflow, ACC_W=33: i_len=3, three products 0x7FFFFFFF; o_ovf=1.
  - Wrap build: o_acc=-2147483651.
  - ALM_DOT_ACC_SAT_EN build: o_acc=4294967295.
- Reset mid-operation: i_rst_n low after 2 of 4 products.
  - All outputs 0 immediately.
  - New vector i_len=2 (5, -9) then gives o_acc=-4 with no residue.
- Max length: i_len=255, every product -2147483648, ACC_W=40.
  - o_acc=-547608330240; o_ovf=0.
